timer_ctrl: RTL and testbench

Synchronous control stage that drives the cascaded asynchronous up/down BCD counter chain of the up2_timer design. It debounces three push-buttons, derives a count tick from the system clock, and runs a run/pause/alarm state machine. It emits clean, non-overlapping active-low INC_N/DEC_N pulses and an active-high CNT_CLR pulse to the counter chain. Counter-chain status (all digits zero / all digits nine) is fed back to stop counting at the range limits.

---
 rtl/timer_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : timer_ctrl                                                 |
// | Brief   : Button debounce, tick prescaler and run/pause/alarm FSM    |
// |           driving an asynchronous up/down BCD counter chain through  |
// |           clean INC_N / DEC_N / CNT_CLR pulses.                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000,
  parameter int PULSE_W    = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic BTN_START,
  input  logic BTN_DIR,
  input  logic BTN_RST,
  input  logic AT_ZERO,
  input  logic AT_MAX,
  output logic INC_N,
  output logic DEC_N,
  output logic CNT_CLR,
  output logic RUN,
  output logic DIR_DOWN,
  output logic ALARM
);

  localparam int c_pre_w = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int c_deb_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_pw_w  = (PULSE_W    > 1) ? $clog2(PULSE_W)    : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_pw_w-1:0]  c_pw_last  = c_pw_w'(PULSE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  // bit 0 = start, bit 1 = direction, bit 2 = clear
  logic [2:0] w_btn;
  logic [2:0] w_deb;
  logic [2:0] r_deb_q;
  logic [2:0] w_ev;

  state_t r_state;
  state_t w_next;

  logic [c_pre_w-1:0] r_pre;
  logic               r_dir;
  logic               r_run;
  logic               r_alarm;

  logic               w_start;
  logic               w_direv;
  logic               w_rstev;
  logic               w_tick;
  logic               w_limit;
  logic               w_req_inc;
  logic               w_req_dec;
  logic               w_req_clr;
  logic               w_pre_clr;
  logic               w_pre_inc;
  logic               w_dir_tgl;

  logic               r_busy;
  logic [c_pw_w-1:0]  r_pcnt;
  logic               r_inc_n;
  logic               r_dec_n;
  logic               r_clr;

  assign w_btn = {BTN_RST, BTN_DIR, BTN_START};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_deb
      logic               r_sync1;
      logic               r_sync2;
      logic               r_lvl;
      logic [c_deb_w-1:0] r_cnt;

      // Two-stage synchronizer, then accept a new level only after it has
      // been seen on DEB_CYCLES consecutive cycles.
      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_lvl   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn[i];
          r_sync2 <= r_sync1;
          if (r_sync2 != r_lvl) begin
            if (r_cnt == c_deb_last) begin
              r_lvl <= r_sync2;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_deb[i] = r_lvl;
    end
  endgenerate

  // Delayed debounced levels for single-cycle rising-edge events.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_deb_q <= 3'b000;
    else     r_deb_q <= w_deb;
  end

  assign w_ev    = w_deb & ~r_deb_q;
  assign w_start = w_ev[0];
  assign w_direv = w_ev[1];
  assign w_rstev = w_ev[2];
  assign w_tick  = (r_state == S_RUN) && (r_pre == c_pre_last);
  assign w_limit = r_dir ? AT_ZERO : AT_MAX;

  // State register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus pulse / prescaler / direction requests.
  // In RUN the cycle that takes a START to PAUSE does not advance the
  // prescaler, so a resume continues from exactly the held value.
  always_comb begin
    w_next    = r_state;
    w_req_inc = 1'b0;
    w_req_dec = 1'b0;
    w_req_clr = 1'b0;
    w_pre_clr = 1'b0;
    w_pre_inc = 1'b0;
    w_dir_tgl = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rstev) begin
          w_req_clr = 1'b1;
        end else if (w_start) begin
          w_next    = S_RUN;
          w_pre_clr = 1'b1;
        end else if (w_direv) begin
          w_dir_tgl = 1'b1;
        end
      end
      S_RUN: begin
        if (w_tick) begin
          w_pre_clr = 1'b1;
          if (w_limit) begin
            w_next = S_ALARM;
          end else begin
            w_req_dec = r_dir;
            w_req_inc = ~r_dir;
            if (w_start) w_next = S_PAUSE;
          end
        end else if (w_start) begin
          w_next = S_PAUSE;
        end else begin
          w_pre_inc = 1'b1;
        end
      end
      S_PAUSE: begin
        if (w_rstev) begin
          w_req_clr = 1'b1;
          w_pre_clr = 1'b1;
          w_next    = S_IDLE;
        end else if (w_start) begin
          w_next = S_RUN;
        end else if (w_direv) begin
          w_dir_tgl = 1'b1;
        end
      end
      S_ALARM: begin
        if (w_rstev) begin
          w_req_clr = 1'b1;
          w_next    = S_IDLE;
        end else if (w_start || w_direv) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tick prescaler, direction flag and registered status outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_pre   <= '0;
      r_dir   <= 1'b1;
      r_run   <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      if (w_pre_clr)      r_pre <= '0;
      else if (w_pre_inc) r_pre <= r_pre + 1'b1;
      if (w_dir_tgl) r_dir <= ~r_dir;
      r_run   <= (w_next == S_RUN);
      r_alarm <= (w_next == S_ALARM);
    end
  end

  // Shared pulse engine: one pulse at a time, requests seen while busy are dropped.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_busy  <= 1'b0;
      r_pcnt  <= '0;
      r_inc_n <= 1'b1;
      r_dec_n <= 1'b1;
      r_clr   <= 1'b0;
    end else if (r_busy) begin
      if (r_pcnt == '0) begin
        r_busy  <= 1'b0;
        r_inc_n <= 1'b1;
        r_dec_n <= 1'b1;
        r_clr   <= 1'b0;
      end else begin
        r_pcnt <= r_pcnt - 1'b1;
      end
    end else if (w_req_inc || w_req_dec || w_req_clr) begin
      r_busy  <= 1'b1;
      r_pcnt  <= c_pw_last;
      r_inc_n <= ~w_req_inc;
      r_dec_n <= ~w_req_dec;
      r_clr   <= w_req_clr;
    end
  end

  assign INC_N    = r_inc_n;
  assign DEC_N    = r_dec_n;
  assign CNT_CLR  = r_clr;
  assign RUN      = r_run;
  assign DIR_DOWN = r_dir;
  assign ALARM    = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_timer_ctrl                                              |
// | Brief   : Directed and randomized bench for timer_ctrl against a     |
// |           behavioural reference model.                               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_timer_ctrl;

  localparam int TICK_DIV = 20;
  localparam int DEB      = 3;
  localparam int PW       = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  localparam int K_NONE = 0, K_INC = 1, K_DEC = 2, K_CLR = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic btn_start = 1'b0, btn_dir = 1'b0, btn_rst = 1'b0;
  logic at_zero = 1'b0, at_max = 1'b0;
  logic inc_n, dec_n, cnt_clr, run, dir_down, alarm;

  int total = 0;
  int bad   = 0;

  // reference model state
  int       m_mode, m_pre, m_left, m_kind;
  bit       m_dir;
  bit [2:0] m_deb, m_deb_q;
  bit [7:0] m_hist [3];

  timer_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB), .PULSE_W(PW)) dut (
    .CLK(clk), .CLR(clr),
    .BTN_START(btn_start), .BTN_DIR(btn_dir), .BTN_RST(btn_rst),
    .AT_ZERO(at_zero), .AT_MAX(at_max),
    .INC_N(inc_n), .DEC_N(dec_n), .CNT_CLR(cnt_clr),
    .RUN(run), .DIR_DOWN(dir_down), .ALARM(alarm)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = M_IDLE; m_pre = 0; m_left = 0; m_kind = K_NONE;
    m_dir = 1'b1; m_deb = 3'b000; m_deb_q = 3'b000;
    for (int b = 0; b < 3; b++) m_hist[b] = 8'h00;
  endfunction

  // One rising clock edge of the reference model, from the inputs present at the edge.
  function automatic void model_edge();
    bit [2:0] raw, ev;
    bit       st, dr, rs, all_new;
    int       req;
    if (clr) begin model_reset(); return; end
    raw = {btn_rst, btn_dir, btn_start};
    ev  = m_deb & ~m_deb_q;
    st = ev[0]; dr = ev[1]; rs = ev[2];
    m_deb_q = m_deb;
    for (int b = 0; b < 3; b++) begin
      // hist bit j holds the raw level j edges ago; the synchronizer adds two
      all_new = 1'b1;
      for (int j = 1; j <= DEB; j++) if (m_hist[b][j] == m_deb[b]) all_new = 1'b0;
      if (all_new) m_deb[b] = ~m_deb[b];
      m_hist[b] = {m_hist[b][6:0], raw[b]};
    end
    req = K_NONE;
    case (m_mode)
      M_IDLE: begin
        if (rs) req = K_CLR;
        else if (st) begin m_mode = M_RUN; m_pre = 0; end
        else if (dr) m_dir = ~m_dir;
      end
      M_RUN: begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre = 0;
          if (m_dir ? at_zero : at_max) m_mode = M_ALARM;
          else begin
            req = m_dir ? K_DEC : K_INC;
            if (st) m_mode = M_PAUSE;
          end
        end else if (st) m_mode = M_PAUSE;
        else m_pre++;
      end
      M_PAUSE: begin
        if (rs) begin req = K_CLR; m_pre = 0; m_mode = M_IDLE; end
        else if (st) m_mode = M_RUN;
        else if (dr) m_dir = ~m_dir;
      end
      default: begin
        if (rs) begin req = K_CLR; m_mode = M_IDLE; end
        else if (st || dr) m_mode = M_IDLE;
      end
    endcase
    if (m_left > 0) m_left--;
    else if (req != K_NONE) begin m_left = PW; m_kind = req; end
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("INC_N",    inc_n,    !(m_left > 0 && m_kind == K_INC));
    chk("DEC_N",    dec_n,    !(m_left > 0 && m_kind == K_DEC));
    chk("CNT_CLR",  cnt_clr,  (m_left > 0 && m_kind == K_CLR));
    chk("RUN",      run,      (m_mode == M_RUN));
    chk("ALARM",    alarm,    (m_mode == M_ALARM));
    chk("DIR_DOWN", dir_down, m_dir);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input bit [2:0] mask, input int hold, input int gap);
    {btn_rst, btn_dir, btn_start} = mask;
    repeat (hold) step();
    {btn_rst, btn_dir, btn_start} = 3'b000;
    repeat (gap) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1;
    model_reset();
    chk("clr_inc_n", inc_n, 1'b1);
    chk("clr_dec_n", dec_n, 1'b1);
    chk("clr_cnt_clr", cnt_clr, 1'b0);
    chk("clr_run", run, 1'b0);
    chk("clr_dir", dir_down, 1'b1);
    chk("clr_alarm", alarm, 1'b0);
    repeat (2) step();
    clr = 1'b0;
  endtask

  initial begin
    int  n;
    bit  prev, found;
    model_reset();
    #2;
    do_clr();
    step();

    // debounce: chatter then a steady press gives exactly one START event
    for (int i = 0; i < 10; i++) begin btn_start = (i % 2 == 0); step(); end
    btn_start = 1'b1;
    repeat (6) step();
    btn_start = 1'b0;
    repeat (2) step();
    chk("deb_run", run, 1'b1);
    btn_start = 1'b1;
    repeat (2) step();
    btn_start = 1'b0;
    repeat (10) step();
    chk("glitch_run", run, 1'b1);

    // steady count-down: 4 low cycles in every 20
    repeat (30) step();
    n = 0; found = 1'b0;
    repeat (40) begin step(); if (dec_n === 1'b0) n++; if (inc_n === 1'b0) found = 1'b1; end
    chk_i("dec_low_cycles", n, 2 * PW);
    chk("inc_idle", found, 1'b0);
    at_zero = 1'b1;
    repeat (25) step();
    chk("zero_alarm", alarm, 1'b1);
    chk("zero_run", run, 1'b0);
    at_zero = 1'b0;

    // count up to the upper limit
    press(3'b010, 6, 6);
    chk("alarm_exit", alarm, 1'b0);
    press(3'b010, 6, 6);
    chk("dir_up", dir_down, 1'b0);
    press(3'b001, 6, 6);
    n = 0; prev = inc_n;
    for (int i = 0; i < 100 && n < 3; i++) begin
      step();
      if (prev === 1'b1 && inc_n === 1'b0) n++;
      prev = inc_n;
    end
    chk_i("inc_pulses", n, 3);
    at_max = 1'b1;
    repeat (25) step();
    chk("max_alarm", alarm, 1'b1);
    press(3'b001, 6, 6);
    chk("max_exit_alarm", alarm, 1'b0);
    chk("max_exit_run", run, 1'b0);
    at_max = 1'b0;

    // pause holds off pulses, clear from pause returns to idle
    press(3'b001, 6, 7);
    press(3'b001, 6, 6);
    chk("pause_run", run, 1'b0);
    n = 0;
    repeat (100) begin step(); if (inc_n === 1'b0 || dec_n === 1'b0) n++; end
    chk_i("pause_pulses", n, 0);
    press(3'b001, 6, 30);
    press(3'b001, 6, 6);
    btn_rst = 1'b1; n = 0;
    repeat (20) begin step(); if (cnt_clr === 1'b1) n++; end
    btn_rst = 1'b0;
    chk_i("clr_width", n, PW);
    chk("clr_idle_run", run, 1'b0);

    // clear request while running is ignored
    press(3'b001, 6, 3);
    btn_rst = 1'b1; n = 0;
    repeat (20) begin step(); if (cnt_clr === 1'b1) n++; end
    btn_rst = 1'b0;
    chk_i("run_clr_ignored", n, 0);
    chk("run_kept", run, 1'b1);

    // asynchronous reset in the middle of an INC_N pulse
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin step(); if (inc_n === 1'b0) found = 1'b1; end
    chk("inc_seen", found, 1'b1);
    step();
    do_clr();

    // randomized presses, chatter, limits and resets
    for (int k = 0; k < 40; k++) begin
      at_zero = ($urandom_range(0, 5) == 0);
      at_max  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 14) == 0) do_clr();
      press(3'($urandom_range(1, 7)), $urandom_range(1, 8), $urandom_range(2, 45));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
